// File: rtl/gate_vector_sequencer.sv
// ============================================================================
// gate_vector_sequencer: applies all 16 vectors to a C=(A|B)^(D&E) block,
// checks the returned bit, reports pass/fail, error count and first failure.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gate_vector_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 5
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic             iC,
  output logic             oA,
  output logic             oB,
  output logic             oD,
  output logic             oE,
  output logic             oBusy,
  output logic             oDone,
  output logic             oPass,
  output logic [CNT_W-1:0] oErrCnt,
  output logic [3:0]       oFirstErr,
  output logic             oFirstErrValid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0]       C_WAIT_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;

  state_t           rState, wState;
  logic [3:0]       rIndex, wIndex;
  logic [3:0]       rWait, wWait;
  logic [CNT_W-1:0] rErrCnt, wErrCnt;
  logic [3:0]       rFirstErr, wFirstErr;
  logic             rFirstErrValid, wFirstErrValid;
  logic             rPass, wPass;
  logic             rBusy, wBusy;
  logic             rDone, wDone;
  logic [3:0]       rVec, wVec;
  logic             wExpected;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      rState         <= IDLE;
      rIndex         <= '0;
      rWait          <= '0;
      rErrCnt        <= '0;
      rFirstErr      <= '0;
      rFirstErrValid <= 1'b0;
      rPass          <= 1'b0;
      rBusy          <= 1'b0;
      rDone          <= 1'b0;
      rVec           <= '0;
    end else begin
      rState         <= wState;
      rIndex         <= wIndex;
      rWait          <= wWait;
      rErrCnt        <= wErrCnt;
      rFirstErr      <= wFirstErr;
      rFirstErrValid <= wFirstErrValid;
      rPass          <= wPass;
      rBusy          <= wBusy;
      rDone          <= wDone;
      rVec           <= wVec;
    end
  end

  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_comb begin
    wState         = rState;
    wIndex         = rIndex;
    wWait          = rWait;
    wErrCnt        = rErrCnt;
    wFirstErr      = rFirstErr;
    wFirstErrValid = rFirstErrValid;
    wPass          = rPass;
    wExpected      = (rIndex[3] | rIndex[2]) ^ (rIndex[1] & rIndex[0]);

    case (rState)
      IDLE: begin
        if (iStart) begin
          wState         = SETTLE;
          wIndex         = '0;
          wWait          = '0;
          wErrCnt        = '0;
          wFirstErr      = '0;
          wFirstErrValid = 1'b0;
          wPass          = 1'b0;
        end
      end
      SETTLE: begin
        if (rWait == C_WAIT_LAST) begin
          wState = SAMPLE;
          wWait  = '0;
        end else begin
          wWait = rWait + 4'd1;
        end
      end
      SAMPLE: begin
        if (iC != wExpected) begin
          if (rErrCnt != C_CNT_MAX) begin
            wErrCnt = rErrCnt + 1'b1;
          end
          if (!rFirstErrValid) begin
            wFirstErr      = rIndex;
            wFirstErrValid = 1'b1;
          end
        end
        if (rIndex == 4'd15) begin
          wState = DONE;
          wPass  = (wErrCnt == '0);
        end else begin
          wIndex = rIndex + 4'd1;
          wState = SETTLE;
        end
      end
      DONE: begin
        wState = IDLE;
      end
      default: begin
        wState = IDLE;
      end
    endcase

    wBusy = (wState == SETTLE) || (wState == SAMPLE);
    wDone = (wState == DONE);
    wVec  = wBusy ? wIndex : 4'd0;
  end

  assign oA             = rVec[3];
  assign oB             = rVec[2];
  assign oD             = rVec[1];
  assign oE             = rVec[0];
  assign oBusy          = rBusy;
  assign oDone          = rDone;
  assign oPass          = rPass;
  assign oErrCnt        = rErrCnt;
  assign oFirstErr      = rFirstErr;
  assign oFirstErrValid = rFirstErrValid;

endmodule

`default_nettype wire

// File: tb/tb_gate_vector_sequencer.sv
// ============================================================================
// tb_gate_vector_sequencer: randomized self-checking bench with a run-schedule
// reference model and a reduced-width second instance.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gate_vector_sequencer;

  localparam int S    = 2;
  localparam int CW   = 5;
  localparam int HOLD = S + 1;
  localparam int RUN  = 16 * HOLD;
  localparam int S3   = 1;
  localparam int CW3  = 3;

  logic          clk = 1'b0;
  logic          iRst = 1'b1;
  logic          iStart = 1'b0;
  logic          iC;
  logic          oA, oB, oD, oE, oBusy, oDone, oPass, oFirstErrValid;
  logic [CW-1:0] oErrCnt;
  logic [3:0]    oFirstErr;
  logic [3:0]    vec;

  logic           en3 = 1'b1;
  logic           start3, c3;
  logic           a3, b3, d3, e3, busy3, done3, pass3, valid3;
  logic [CW3-1:0] err3;
  logic [3:0]     first3;
  logic [3:0]     vec3;
  int             busy3Cnt = 0;

  logic        stuckEn = 1'b0;
  logic        stuckVal = 1'b0;
  logic [15:0] mask = 16'h0;
  bit          chkEn = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic gold(input logic [3:0] v);
    return (v[3] | v[2]) ^ (v[1] & v[0]);
  endfunction

  assign vec    = {oA, oB, oD, oE};
  assign vec3   = {a3, b3, d3, e3};
  assign start3 = iStart & en3;
  assign c3     = ~gold(vec3);

  always_comb iC = stuckEn ? stuckVal : (gold(vec) ^ mask[vec]);

  gate_vector_sequencer #(.SETTLE_CYCLES(S), .CNT_W(CW)) dut (
    .iClk(clk), .iRst(iRst), .iStart(iStart), .iC(iC),
    .oA(oA), .oB(oB), .oD(oD), .oE(oE),
    .oBusy(oBusy), .oDone(oDone), .oPass(oPass), .oErrCnt(oErrCnt),
    .oFirstErr(oFirstErr), .oFirstErrValid(oFirstErrValid)
  );

  gate_vector_sequencer #(.SETTLE_CYCLES(S3), .CNT_W(CW3)) dut3 (
    .iClk(clk), .iRst(iRst), .iStart(start3), .iC(c3),
    .oA(a3), .oB(b3), .oD(d3), .oE(e3),
    .oBusy(busy3), .oDone(done3), .oPass(pass3), .oErrCnt(err3),
    .oFirstErr(first3), .oFirstErrValid(valid3)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is a numbered sequence of RUN busy cycles; the
  // vector is cycle/HOLD and the last cycle of each hold window is sampled.
  bit mBusy, mDone, mPass, mFirstV;
  int mCycle, mErr, mFirst, mIdx, eVec;

  always @(posedge clk or posedge iRst) begin
    if (iRst) begin
      mBusy = 0; mDone = 0; mPass = 0; mFirstV = 0;
      mCycle = 0; mErr = 0; mFirst = 0;
    end else if (mDone) begin
      mDone = 0;
    end else if (mBusy) begin
      mIdx = mCycle / HOLD;
      if ((mCycle % HOLD) == HOLD - 1 && iC !== gold(mIdx[3:0])) begin
        if (mErr < (1 << CW) - 1) mErr++;
        if (!mFirstV) begin
          mFirstV = 1;
          mFirst  = mIdx;
        end
      end
      if (mCycle == RUN - 1) begin
        mBusy = 0;
        mDone = 1;
        mPass = (mErr == 0);
      end else begin
        mCycle++;
      end
    end else if (iStart) begin
      mBusy = 1; mCycle = 0; mErr = 0; mFirst = 0; mFirstV = 0; mPass = 0;
    end
  end

  always @(negedge clk) begin
    if (busy3) busy3Cnt++;
    if (chkEn) begin
      eVec = mBusy ? mCycle / HOLD : 0;
      check("vector", int'(vec), eVec);
      check("busy", int'(oBusy), int'(mBusy));
      check("done", int'(oDone), int'(mDone));
      check("errCnt", int'(oErrCnt), mErr);
      check("firstErr", int'(oFirstErr), mFirst);
      check("firstErrValid", int'(oFirstErrValid), int'(mFirstV));
      check("pass", int'(oPass), int'(mPass));
    end
  end

  // One run from a one-cycle start; optionally noisy iStart while busy.
  task automatic runOne(input bit noisy, output int busyCnt, output int doneCnt);
    @(negedge clk) iStart = 1'b1;
    @(negedge clk) iStart = 1'b0;
    busyCnt = 0;
    doneCnt = 0;
    for (int k = 0; k < RUN + 2; k++) begin
      if (oBusy) busyCnt++;
      if (oDone) doneCnt++;
      iStart = (noisy && k < RUN) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    iStart = 1'b0;
  endtask

  task automatic expectResult(input string tag, input int err, input int first,
                              input int valid, input int pass);
    check({tag, ".errCnt"}, int'(oErrCnt), err);
    check({tag, ".firstErr"}, int'(oFirstErr), first);
    check({tag, ".firstErrValid"}, int'(oFirstErrValid), valid);
    check({tag, ".pass"}, int'(oPass), pass);
  endtask

  initial begin
    int  busyCnt, doneCnt, got, lowest;
    bit  found;

    repeat (2) @(negedge clk);
    chkEn = 1'b1;
    check("reset.busy", int'(oBusy), 0);
    check("reset.vector", int'(vec), 0);
    check("reset.errCnt", int'(oErrCnt), 0);
    check("reset.pass", int'(oPass), 0);
    iRst = 1'b0;

    // Golden loopback; the CNT_W=3 instance runs an inverted model alongside.
    runOne(1'b0, busyCnt, doneCnt);
    en3 = 1'b0;
    check("golden.busyCycles", busyCnt, 48);
    check("golden.donePulses", doneCnt, 1);
    expectResult("golden", 0, 0, 0, 1);
    check("sat.busyCycles", busy3Cnt, 32);
    check("sat.errCnt", int'(err3), 7);
    check("sat.firstErr", int'(first3), 0);
    check("sat.firstErrValid", int'(valid3), 1);
    check("sat.pass", int'(pass3), 0);

    stuckEn = 1'b1; stuckVal = 1'b0;
    runOne(1'b0, busyCnt, doneCnt);
    expectResult("stuck0", 10, 3, 1, 0);

    stuckVal = 1'b1;
    runOne(1'b0, busyCnt, doneCnt);
    expectResult("stuck1", 6, 0, 1, 0);

    stuckEn = 1'b0; mask = 16'hFFFF;
    runOne(1'b0, busyCnt, doneCnt);
    expectResult("inverted", 16, 0, 1, 0);

    mask = 16'h0200;
    runOne(1'b0, busyCnt, doneCnt);
    expectResult("corrupt9", 1, 9, 1, 0);

    // Starts during busy must be ignored and must not clear the counters.
    stuckEn = 1'b1; stuckVal = 1'b0;
    runOne(1'b1, busyCnt, doneCnt);
    check("noisy.busyCycles", busyCnt, RUN);
    check("noisy.donePulses", doneCnt, 1);
    expectResult("noisy", 10, 3, 1, 0);
    stuckEn = 1'b0;

    for (int r = 0; r < 4; r++) begin
      mask = 16'($urandom);
      runOne(1'b0, busyCnt, doneCnt);
      found = 0; lowest = 0;
      for (int i = 0; i < 16; i++) begin
        if (mask[i] && !found) begin
          found = 1;
          lowest = i;
        end
      end
      expectResult("random", $countones(mask), lowest, int'(found), int'(mask == 0));
    end

    // Reset in the middle of vector 7.
    mask = 16'h0;
    @(negedge clk) iStart = 1'b1;
    @(negedge clk) iStart = 1'b0;
    got = 0;
    for (int k = 0; k < RUN; k++) begin
      if (oBusy && vec == 4'd7) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    check("reset.reachedIdx7", got, 1);
    #2 iRst = 1'b1;
    #1;
    check("midReset.vector", int'(vec), 0);
    check("midReset.busy", int'(oBusy), 0);
    check("midReset.done", int'(oDone), 0);
    check("midReset.errCnt", int'(oErrCnt), 0);
    check("midReset.firstErrValid", int'(oFirstErrValid), 0);
    #1 iRst = 1'b0;
    doneCnt = 0;
    for (int k = 0; k < 4 * HOLD; k++) begin
      @(negedge clk);
      if (oDone) doneCnt++;
    end
    check("midReset.noDone", doneCnt, 0);
    runOne(1'b0, busyCnt, doneCnt);
    check("afterReset.busyCycles", busyCnt, RUN);
    expectResult("afterReset", 0, 0, 0, 1);

    // Start held high: back-to-back runs with one idle cycle between.
    @(negedge clk) iStart = 1'b1;
    for (int run = 0; run < 2; run++) begin
      got = 0;
      for (int k = 0; k < RUN + 10; k++) begin
        @(negedge clk);
        if (oDone) begin
          got = 1;
          break;
        end
      end
      check("held.doneSeen", got, 1);
      @(negedge clk);
      check("held.gapBusy", int'(oBusy), 0);
      check("held.gapDone", int'(oDone), 0);
      @(negedge clk);
      check("held.restart", int'(oBusy), 1);
    end
    iStart = 1'b0;
    got = 0;
    for (int k = 0; k < RUN + 10; k++) begin
      @(negedge clk);
      if (oDone) begin
        got = 1;
        break;
      end
    end
    check("held.finalDone", got, 1);
    repeat (2) @(negedge clk);
    expectResult("held", 0, 0, 0, 1);

    chkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
